led_row_scanner: RTL and testbench

//   Sequencer that multiplexes an 8x8 LED matrix one row at a time. Drives ena/in of the
//   3-to-8 row decoder (row_ena/row_sel) and the 8 column lines. Fetches each row's

---
 rtl/led_row_scanner_if.sv | 34 +++
 rtl/led_row_scanner.sv | 180 ++++++++++++++++++
 tb/tb_led_row_scanner.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_row_scanner_if.sv
// ============================================================================
// Module      : led_row_scanner_if
// Description : Row-fetch handshake between the LED row scanner (master) and
//               the board memory that supplies one row of pixels per request.
// Signals     : row_data_req  master->slave  request pixels for row_addr
//               row_addr[2:0] master->slave  row being fetched
//               row_data_ack  slave->master  row_data valid; transfer on req&ack
//               row_data[7:0] slave->master  pixel bits, bit i = column i
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_row_scanner_if;
    logic       row_data_req;
    logic [2:0] row_addr;
    logic       row_data_ack;
    logic [7:0] row_data;

    modport master (
        output row_data_req,
        output row_addr,
        input  row_data_ack,
        input  row_data
    );

    modport slave (
        input  row_data_req,
        input  row_addr,
        output row_data_ack,
        output row_data
    );
endinterface

`default_nettype wire

// File: rtl/led_row_scanner.sv
// ============================================================================
// Module      : led_row_scanner
// Description : Multiplexes an 8x8 LED matrix one row at a time. Each row is
//               fetched over the req/ack interface, held blanked for
//               BLANK_CYCLES, then lit for DWELL_CYCLES. All rows are dark
//               while row_sel/cols change, so lit rows never glitch.
// Optional    : ROW_SCANNER_TIMEOUT_EN - abandon a fetch after TIMEOUT_CYCLES
//               without ack, show the row dark and pulse fetch_timeout.
// Ports       : clk            system clock, rising edge
//               rst_n          asynchronous active-low reset
//               ena            scan enable (sampled in IDLE / last lit cycle)
//               fetch          row-fetch handshake (master modport)
//               row_ena        row decoder enable, high only while lit
//               row_sel[2:0]   row decoder input, current row
//               cols[7:0]      registered column drive
//               frame_done     1-cycle pulse after row 7 has been lit
//               fetch_timeout  1-cycle pulse on fetch timeout (0 without macro)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_row_scanner #(
    parameter int BLANK_CYCLES   = 2,
    parameter int DWELL_CYCLES   = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          ena,
    led_row_scanner_if.master  fetch,
    output logic               row_ena,
    output logic [2:0]         row_sel,
    output logic [7:0]         cols,
    output logic               frame_done,
    output logic               fetch_timeout
);

    // Counter is shared by BLANK, ACTIVE and (optionally) FETCH, so it is
    // sized for the longest of the three intervals.
    localparam int c_max_ab    = (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
    localparam int c_max_cycles = (c_max_ab > TIMEOUT_CYCLES) ? c_max_ab : TIMEOUT_CYCLES;
    localparam int c_cnt_w     = $clog2(c_max_cycles + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_dwell_last = c_cnt_w'(DWELL_CYCLES - 1);
`ifdef ROW_SCANNER_TIMEOUT_EN
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_BLANK  = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           row_q, row_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [7:0]           cols_q, cols_d;
    logic                 frame_done_q, frame_done_d;
`ifdef ROW_SCANNER_TIMEOUT_EN
    logic                 fetch_timeout_q, fetch_timeout_d;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        cnt_d        = cnt_q;
        cols_d       = cols_q;
        frame_done_d = 1'b0;
`ifdef ROW_SCANNER_TIMEOUT_EN
        fetch_timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (ena) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                // An ack is checked first so that it wins over a timeout
                // landing in the same cycle.
                if (fetch.row_data_ack) begin
                    cols_d  = fetch.row_data;
                    cnt_d   = '0;
                    state_d = ST_BLANK;
                end
`ifdef ROW_SCANNER_TIMEOUT_EN
                else if (cnt_q == c_timeout_last) begin
                    cols_d          = 8'h00;
                    cnt_d           = '0;
                    fetch_timeout_d = 1'b1;
                    state_d         = ST_BLANK;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
`endif
            end

            ST_BLANK: begin
                if (cnt_q == c_blank_last) begin
                    cnt_d   = '0;
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            ST_ACTIVE: begin
                if (cnt_q == c_dwell_last) begin
                    cnt_d        = '0;
                    row_d        = row_q + 3'd1;  // natural 3-bit wrap 7->0
                    frame_done_d = (row_q == 3'd7);
                    state_d      = ena ? ST_FETCH : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            row_q        <= 3'd0;
            cnt_q        <= '0;
            cols_q       <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            cnt_q        <= cnt_d;
            cols_q       <= cols_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef ROW_SCANNER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_timeout_q <= 1'b0;
        end else begin
            fetch_timeout_q <= fetch_timeout_d;
        end
    end

    assign fetch_timeout = fetch_timeout_q;
`else
    assign fetch_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs: registered or decoded straight from state, so reset forces
    // every one of them low without waiting for a clock edge.
    // ------------------------------------------------------------------
    assign fetch.row_data_req = (state_q == ST_FETCH);
    assign fetch.row_addr     = row_q;
    assign row_ena            = (state_q == ST_ACTIVE);
    assign row_sel            = row_q;
    assign cols               = cols_q;
    assign frame_done         = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_led_row_scanner.sv
// ============================================================================
// Module      : tb_led_row_scanner
// Description : Self-checking bench for led_row_scanner with BLANK=2, DWELL=4,
//               TIMEOUT=16. Cycle table for start-up/disable, then directed
//               sequences for sweep, frame wrap, reset, handshake and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_row_scanner;

    localparam int BLANK_CYCLES   = 2;
    localparam int DWELL_CYCLES   = 4;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int ROW_PERIOD     = 1 + BLANK_CYCLES + DWELL_CYCLES;  // 7

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       row_ena;
    logic [2:0] row_sel;
    logic [7:0] cols;
    logic       frame_done;
    logic       fetch_timeout;

    logic       tb_ack;
    logic [7:0] tb_data;
    logic       tb_auto;

    int n_cmp = 0;
    int n_err = 0;
    int fd_count;

    led_row_scanner_if bus ();

    assign bus.row_data_ack = tb_ack;
    assign bus.row_data     = tb_auto ? (8'h01 << bus.row_addr) : tb_data;

    led_row_scanner #(
        .BLANK_CYCLES   (BLANK_CYCLES),
        .DWELL_CYCLES   (DWELL_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .fetch         (bus),
        .row_ena       (row_ena),
        .row_sel       (row_sel),
        .cols          (cols),
        .frame_done    (frame_done),
        .fetch_timeout (fetch_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ena;
        logic       ack;
        logic [7:0] data;
        logic       exp_req;
        logic [2:0] exp_row;
        logic       exp_rena;
        logic [7:0] exp_cols;
    } vec_t;

    vec_t tbl [19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},      32'(bus.row_data_req), 32'd0);
        check({tag, "_row_ena"},  32'(row_ena),          32'd0);
        check({tag, "_row_sel"},  32'(row_sel),          32'd0);
        check({tag, "_row_addr"}, 32'(bus.row_addr),     32'd0);
        check({tag, "_cols"},     32'(cols),             32'd0);
        check({tag, "_fd"},       32'(frame_done),       32'd0);
        check({tag, "_fto"},      32'(fetch_timeout),    32'd0);
    endtask

    // Reset with ena low, release just after an edge, then set up the bench
    // inputs for the next sequence.
    task automatic do_reset();
        ena     = 1'b0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n   = 1'b1;
    endtask

    // Expected behaviour with ack held high after a start from IDLE with ena=1:
    // cycle j after release: phase 0 FETCH, 1..2 BLANK, 3..6 ACTIVE.
    task automatic sweep(input int jf, input int jl);
        for (int j = jf; j <= jl; j++) begin
            int ph;
            int r;
            tick();
            ph = j % ROW_PERIOD;
            r  = (j / ROW_PERIOD) % 8;
            check("sw_req",      32'(bus.row_data_req), 32'(ph == 0));
            check("sw_row_sel",  32'(row_sel),          32'(r));
            check("sw_row_addr", 32'(bus.row_addr),     32'(r));
            check("sw_row_ena",  32'(row_ena),          32'(ph > BLANK_CYCLES));
            check("sw_frame_done", 32'(frame_done),     32'((ph == 0) && (j >= ROW_PERIOD) && (r == 0)));
            check("sw_fto",      32'(fetch_timeout),    32'd0);
            if (ph != 0) begin
                check("sw_cols", 32'(cols), 32'(8'h01 << r));
            end
            if (frame_done) fd_count++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                ena  ack  data   req row rena cols
        tbl[0]  = '{1'b0, 1'b1, 8'hAA, 1'b0, 3'd0, 1'b0, 8'h00};  // IDLE, ack ignored
        tbl[1]  = '{1'b1, 1'b1, 8'hAA, 1'b1, 3'd0, 1'b0, 8'h00};  // -> FETCH row 0
        tbl[2]  = '{1'b1, 1'b0, 8'h5A, 1'b1, 3'd0, 1'b0, 8'h00};  // wait for ack
        tbl[3]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 3'd0, 1'b0, 8'h3C};  // load -> BLANK
        tbl[4]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 3'd0, 1'b0, 8'h3C};  // BLANK 2
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 8'h3C};  // ACTIVE 1
        tbl[6]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 3'd0, 1'b1, 8'h3C};
        tbl[7]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 3'd0, 1'b1, 8'h3C};
        tbl[8]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 3'd0, 1'b1, 8'h3C};  // ACTIVE 4
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0, 8'h3C};  // FETCH row 1
        tbl[10] = '{1'b1, 1'b1, 8'h81, 1'b0, 3'd1, 1'b0, 8'h81};  // load -> BLANK
        tbl[11] = '{1'b0, 1'b1, 8'h18, 1'b0, 3'd1, 1'b0, 8'h81};  // ena drop mid-row
        tbl[12] = '{1'b0, 1'b1, 8'h18, 1'b0, 3'd1, 1'b1, 8'h81};
        tbl[13] = '{1'b0, 1'b1, 8'h18, 1'b0, 3'd1, 1'b1, 8'h81};
        tbl[14] = '{1'b0, 1'b1, 8'h18, 1'b0, 3'd1, 1'b1, 8'h81};
        tbl[15] = '{1'b0, 1'b1, 8'h18, 1'b0, 3'd1, 1'b1, 8'h81};  // row completes
        tbl[16] = '{1'b0, 1'b1, 8'h18, 1'b0, 3'd2, 1'b0, 8'h81};  // IDLE
        tbl[17] = '{1'b0, 1'b1, 8'h18, 1'b0, 3'd2, 1'b0, 8'h81};  // still IDLE
        tbl[18] = '{1'b1, 1'b0, 8'h18, 1'b1, 3'd2, 1'b0, 8'h81};  // FETCH row 2

        tb_ack   = 1'b0;
        tb_data  = 8'h00;
        tb_auto  = 1'b0;
        fd_count = 0;

        // ---------------- reset state ----------------
        ena   = 1'b0;
        rst_n = 1'b0;
        #2;
        check_all_zero("rst_async");
        tick();
        check_all_zero("rst_held");

        // ---------------- cycle table ----------------
        rst_n = 1'b1;
        for (int i = 0; i < 19; i++) begin
            ena     = tbl[i].ena;
            tb_ack  = tbl[i].ack;
            tb_data = tbl[i].data;
            tick();
            check($sformatf("tbl%0d_req", i),      32'(bus.row_data_req), 32'(tbl[i].exp_req));
            check($sformatf("tbl%0d_row_sel", i),  32'(row_sel),          32'(tbl[i].exp_row));
            check($sformatf("tbl%0d_row_addr", i), 32'(bus.row_addr),     32'(tbl[i].exp_row));
            check($sformatf("tbl%0d_row_ena", i),  32'(row_ena),          32'(tbl[i].exp_rena));
            check($sformatf("tbl%0d_cols", i),     32'(cols),             32'(tbl[i].exp_cols));
            check($sformatf("tbl%0d_fd", i),       32'(frame_done),       32'd0);
        end

        // ---------------- sweep + wrap: two frames and one row ----------------
        do_reset();
        tb_auto  = 1'b1;
        tb_ack   = 1'b1;
        ena      = 1'b1;
        fd_count = 0;
        sweep(0, 2 * 8 * ROW_PERIOD + ROW_PERIOD - 1);
        check("wrap_frame_done_count", 32'(fd_count), 32'd2);

        // ---------------- reset mid-ACTIVE on row 3 ----------------
        do_reset();
        ena = 1'b1;
        sweep(0, 3 * ROW_PERIOD + BLANK_CYCLES + 2);  // row 3, second lit cycle
        check("pre_rst_row_ena", 32'(row_ena), 32'd1);
        check("pre_rst_row_sel", 32'(row_sel), 32'd3);
        rst_n = 1'b0;
        #2;
        check_all_zero("rst_mid");
        tick();
        tick();
        check_all_zero("rst_mid_held");
        rst_n = 1'b1;
        fd_count = 0;
        sweep(0, ROW_PERIOD);  // first req must address row 0 again
        check("rst_mid_no_fd", 32'(fd_count), 32'd0);

        // ---------------- delayed ack on row 2 ----------------
        do_reset();
        ena = 1'b1;
        sweep(0, 2 * ROW_PERIOD - 1);  // rows 0,1 done; in last lit cycle of row 1
        tb_ack = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("hs_req_c%0d", k),     32'(bus.row_data_req), 32'd1);
            check($sformatf("hs_addr_c%0d", k),    32'(bus.row_addr),     32'd2);
            check($sformatf("hs_row_ena_c%0d", k), 32'(row_ena),          32'd0);
            check($sformatf("hs_cols_c%0d", k),    32'(cols),             32'h02);
        end
        tb_ack = 1'b1;
        #1;
        check("hs_req_c6",  32'(bus.row_data_req), 32'd1);
        check("hs_cols_c6", 32'(cols),             32'h02);
        tick();
        check("hs_req_drop",  32'(bus.row_data_req), 32'd0);
        check("hs_cols_load", 32'(cols),             32'h04);
        check("hs_blank_ena", 32'(row_ena),          32'd0);
        tick();
        check("hs_blank2_ena", 32'(row_ena), 32'd0);
        for (int k = 1; k <= DWELL_CYCLES; k++) begin
            tick();
            check($sformatf("hs_lit%0d_ena", k),  32'(row_ena), 32'd1);
            check($sformatf("hs_lit%0d_sel", k),  32'(row_sel), 32'd2);
            check($sformatf("hs_lit%0d_cols", k), 32'(cols),    32'h04);
        end
        tick();
        check("hs_next_fetch", 32'(bus.row_addr), 32'd3);

        // ---------------- disable during row 5 ----------------
        do_reset();
        ena = 1'b1;
        sweep(0, 5 * ROW_PERIOD + BLANK_CYCLES + 1);  // first lit cycle of row 5
        ena = 1'b0;
        sweep(5 * ROW_PERIOD + BLANK_CYCLES + 2, 6 * ROW_PERIOD - 1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("dis_idle%0d_req", k), 32'(bus.row_data_req), 32'd0);
            check($sformatf("dis_idle%0d_ena", k), 32'(row_ena),          32'd0);
            check($sformatf("dis_idle%0d_sel", k), 32'(row_sel),          32'd6);
        end
        ena = 1'b1;
        tick();
        check("reen_req",  32'(bus.row_data_req), 32'd1);
        check("reen_addr", 32'(bus.row_addr),     32'd6);
        tick();
        check("reen_cols", 32'(cols), 32'h40);

`ifdef ROW_SCANNER_TIMEOUT_EN
        // ---------------- fetch timeout ----------------
        do_reset();
        ena = 1'b1;
        sweep(0, ROW_PERIOD - 1);  // row 0 loaded with 8'h01
        tb_ack = 1'b0;
        for (int k = 1; k <= TIMEOUT_CYCLES; k++) begin
            tick();
            check($sformatf("to_req_c%0d", k), 32'(bus.row_data_req), 32'd1);
            check($sformatf("to_fto_c%0d", k), 32'(fetch_timeout),    32'd0);
        end
        tick();
        check("to_pulse",    32'(fetch_timeout),    32'd1);
        check("to_req_drop", 32'(bus.row_data_req), 32'd0);
        check("to_cols",     32'(cols),             32'h00);
        tick();
        check("to_pulse_end", 32'(fetch_timeout), 32'd0);
        for (int k = 1; k <= DWELL_CYCLES; k++) begin
            tick();
            check($sformatf("to_dark%0d_ena", k),  32'(row_ena), 32'd1);
            check($sformatf("to_dark%0d_sel", k),  32'(row_sel), 32'd1);
            check($sformatf("to_dark%0d_cols", k), 32'(cols),    32'h00);
        end
        for (int k = 1; k <= TIMEOUT_CYCLES; k++) begin
            tick();
        end
        check("to_last_req", 32'(bus.row_data_req), 32'd1);
        tb_ack = 1'b1;
        tick();
        check("to_ack_wins_fto",  32'(fetch_timeout), 32'd0);
        check("to_ack_wins_cols", 32'(cols),          32'h04);
`else
        check("no_macro_fto", 32'(fetch_timeout), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
